serial_tx: RTL
==============

# serial_tx

Parallel-in, serial-out framed transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line as start bit, data bits, optional parity bit, and stop bit, each held DIV clocks. It is the transmit end of the team's serial links. Examples are the GPU test harness debug line and the controller/memory-card style bit streams. It pairs with a shift-register-based receiver on the far side.

## Interface
- WIDTH, 8: data bits per frame; legal range ≥2.
- DIV, 4: clocks per serial bit; legal range ≥2.

- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- data_in  input  WIDTH  word to send; sampled on accept
- msb_first  input  1  bit order, sampled on accept; 0 = LSB first
- load_valid  input  1  producer has a word
- load_ready  output  1  transmitter idle, can accept
- s_out  output  1  serial line; idles high
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse in the last cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY (only when configured), STOP.
- IDLE behaviour:
  - load_ready=1, busy=0, s_out=1.
  - Accept occurs on a clk edge where load_valid & load_ready.
  - On accept: latch data_in into the shift register, latch msb_first, clear the bit-period counter and bit index, go to START.
- START: s_out=0 for DIV cycles, then DATA.
- DATA behaviour:
  - s_out = shift-register LSB when msb_first=0, MSB otherwise.
  - After each DIV cycles, shift toward the output end and increment the index.
  - After WIDTH bits, go to PARITY if configured, else STOP.
- PARITY: s_out = XOR of the latched word, which gives even parity. Held DIV cycles, then STOP.
- STOP: s_out=1 for DIV cycles. done=1 in the final cycle. Then IDLE.
- Outputs:
  - load_ready = (state==IDLE).
  - busy = !load_ready.
  - s_out, done and busy are registered or decoded from registered state only. No combinational path from any input.
- load_valid while busy is ignored; data_in may change freely after accept.
- Bit-period counter width: $clog2(DIV). It wraps DIV-1→0 and asserts an internal tick on DIV-1.
- Bit index width: $clog2(WIDTH+1).

## Timing
- Reset values (held while reset=1, and immediately on a mid-frame assertion):
  - state=IDLE, s_out=1, busy=0, done=0, load_ready=1, counters=0.
  - The frame in progress is abandoned and is not resumed.
- Let T0 be the accepting edge and N = WIDTH+2, or WIDTH+3 with parity.
- Frame bit k (k=0 is start) is driven from edge T0+k·DIV to edge T0+(k+1)·DIV.
- done is high from edge T0+N·DIV−1 to T0+N·DIV.
- State is IDLE and load_ready=1 from edge T0+N·DIV.
- Earliest next accept is edge T0+N·DIV+1, so the minimum gap between frames is 1 idle cycle of s_out=1.
- load_valid asserted in the same cycle that done is high is not accepted (load_ready=0).

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state exists, frames carry an even-parity bit between the data and stop bits, and N=WIDTH+3.
- SERIAL_TX_PARITY_EN undefined: no PARITY state or parity logic, and N=WIDTH+2.

## Structure
- Package serial_tx_pkg holds:
  - the state enum typedef (PARITY encoding always present in the type and unreachable when the macro is undefined);
  - a function frame_bits(width) returning N under the current configuration, for use by benches.
- Sub-module serial_tx_baud_tick, parameter DIV:
  - ports clk, reset, clr, en, tick;
  - a bit-period counter with a terminal-count pulse.
- Everything else lives in serial_tx.

## Test plan
- **Reset state:** reset pulse with load_valid=1 → s_out=1, load_ready=1, busy=0, done=0 during reset; nothing is accepted before the first post-reset edge.
- **LSB-first frame:** WIDTH=8, DIV=4, no parity, data_in=8'hA5, msb_first=0.
  - s_out bit sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles.
  - done high in cycle 39 after accept; load_ready high at cycle 40.
- **MSB-first with parity:** data_in=8'hA5, msb_first=1, SERIAL_TX_PARITY_EN defined → sequence 0,1,0,1,0,0,1,0,1,0,1, where parity=0. A second frame with 8'h07 gives parity=1.
- **Back-to-back:** load_valid held high with words 8'h01 then 8'hFF.
  - The second word is accepted exactly 1 cycle after the first frame's IDLE entry.
  - Words offered while busy are not accepted, and data_in changes while busy do not corrupt s_out.
- **Mid-frame reset:** reset asserted during data bit 3 → s_out=1 and load_ready=1 asynchronously. After release, a new word 8'h3C is sent with correct framing from a fresh start bit.
- **Minimum divider:** DIV=2, WIDTH=2, data 2'b10, LSB first → s_out 0,0,0,0,1,1,1,1 (start, data bit0=0, data bit1=1, stop). done in cycle 7 after accept.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Purpose: shared types and helpers for the serial_tx framed transmitter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds an even-parity bit per frame).
package serial_tx_pkg;

  // PARITY always has an encoding. It is simply never entered when the
  // parity feature is compiled out.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits per frame: start + data + [parity] + stop.
  function automatic int frame_bits(input int width);
`ifdef SERIAL_TX_PARITY_EN
    return width + 3;
`else
    return width + 2;
`endif
  endfunction

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Purpose: bit-period counter; pulses tick in the last clock of every DIV-clock bit period.
// Latency: tick is combinational from the registered count and en; count advances 1/clk while en.
// Backpressure: none; clr has priority over en and restarts the period at 0.
// Ports: clk, reset (async, active-high), clr (restart period), en (count), tick (terminal count).
module serial_tx_baud_tick
  import serial_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Purpose: parallel-in serial-out framed transmitter (start, WIDTH data, [even parity], stop; DIV clocks per bit).
// Latency: first start-bit clock follows the accepting edge; frame lasts N*DIV clocks, then 1 idle clock minimum.
// Backpressure: load_ready is high only in IDLE; load_valid while busy is ignored.
// Ports: clk, reset (async, active-high); data_in/msb_first/load_valid/load_ready load handshake;
//        s_out serial line (idles high), busy (frame in progress), done (last clock of stop bit).
// Optional feature macro: SERIAL_TX_PARITY_EN (even-parity bit between the data and stop bits).
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  localparam int IDXW = $clog2(WIDTH + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic             msb_q;
  logic [IDXW-1:0]  idx_q;
  logic             accept;
  logic             tick;
  logic             tick_en;

`ifdef SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  // The counter runs through every non-idle state and wraps on its own,
  // so it only needs an explicit clear when a frame is accepted.
  assign tick_en = (state_q != IDLE);

  serial_tx_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from registered state and datapath only; the one
  // input-dependent term (accept) feeds next-state and the counter clear.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    s_out      = 1'b1;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        accept     = load_valid;
        if (load_valid) begin
          state_d = START;
        end
      end
      START: begin
        s_out = 1'b0;
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        s_out = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
        if (tick && (idx_q == LAST_IDX)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        s_out = par_q;
        if (tick) begin
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        s_out = 1'b1;
        done  = tick;
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy = !load_ready;
  end

  // The shift register moves toward whichever end s_out reads from, so
  // the next bit is always at the same position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      msb_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      shreg_q <= data_in;
      msb_q   <= msb_first;
      idx_q   <= '0;
    end else if ((state_q == DATA) && tick) begin
      shreg_q <= msb_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      idx_q   <= idx_q + 1'b1;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken at accept because the shift register is consumed
  // while the data bits go out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^data_in;
    end
  end
`endif

endmodule
